// File: rtl/vx_ag_tcu_fedp_bscale_pkg.sv
// Shared definitions for the AG tensor-core block-scaled fused dot product:
// operand format encodings, datapath widths and the pipeline latency rule.
package vx_ag_tcu_fedp_bscale_pkg;

   typedef enum logic [2:0] {
      AG_FMT_I8 = 3'd1,
      AG_FMT_U8 = 3'd2,
      AG_FMT_I4 = 3'd3,
      AG_FMT_U4 = 3'd4
   } ag_fmt_e;

   // Width of one lane sum before format extension, and after it.
   localparam int PRODW = 18;
   localparam int PSELW = 19;

   // S1 + S2 + intra tree + shift + inter tree + accumulate.
   function automatic int fedp_bscale_latency(input int n);
      return 4 + $clog2(n);
   endfunction

   function automatic logic fmt_is_valid(input logic [2:0] f);
      return (f >= AG_FMT_I8) && (f <= AG_FMT_U4);
   endfunction

   function automatic logic fmt_is_signed(input logic [2:0] f);
      return (f == AG_FMT_I8) || (f == AG_FMT_I4);
   endfunction

endpackage

// File: rtl/vx_ag_tcu_fedp_bscale_lane_mul.sv
// One lane of the dot product: packed 8-bit or 4-bit products (S1) followed by
// the lane sum and format-dependent sign/zero extension (S2).
module vx_ag_tcu_fedp_bscale_lane_mul
   import vx_ag_tcu_fedp_bscale_pkg::*;
(
   input  logic                    i_clk,
   input  logic                    i_enable,
   input  logic [2:0]              i_fmt,
   input  logic [31:0]             i_a,
   input  logic [31:0]             i_b,
   output logic signed [PSELW-1:0] o_val
);

   // Products are taken modulo the field width; every legal format's true
   // pair/quad sum fits that width under its own signedness.
   function automatic logic [16:0] mul8(input logic s, input logic [7:0] a,
                                        input logic [7:0] b);
      return 17'($signed({s & a[7], a})) * 17'($signed({s & b[7], b}));
   endfunction

   function automatic logic [9:0] mul4(input logic s, input logic [3:0] a,
                                       input logic [3:0] b);
      return 10'($signed({s & a[3], a})) * 10'($signed({s & b[3], b}));
   endfunction

   logic                    w_sgn;
   logic [16:0]             w_p8 [2];
   logic [9:0]              w_p4 [2];
   logic [16:0]             r_p8 [2];
   logic [9:0]              r_p4 [2];
   logic [2:0]              r_fmt;
   logic [PRODW-1:0]        w_lane;
   logic signed [PSELW-1:0] w_val;
   logic signed [PSELW-1:0] r_val;

   // S1 products: two byte-pair sums and two nibble-quad sums per lane.
   always_comb begin
      w_sgn   = fmt_is_signed(i_fmt);
      w_p8[0] = mul8(w_sgn, i_a[7:0],   i_b[7:0])   + mul8(w_sgn, i_a[15:8],  i_b[15:8]);
      w_p8[1] = mul8(w_sgn, i_a[23:16], i_b[23:16]) + mul8(w_sgn, i_a[31:24], i_b[31:24]);
      w_p4[0] = mul4(w_sgn, i_a[3:0],   i_b[3:0])   + mul4(w_sgn, i_a[7:4],   i_b[7:4])
              + mul4(w_sgn, i_a[11:8],  i_b[11:8])  + mul4(w_sgn, i_a[15:12], i_b[15:12]);
      w_p4[1] = mul4(w_sgn, i_a[19:16], i_b[19:16]) + mul4(w_sgn, i_a[23:20], i_b[23:20])
              + mul4(w_sgn, i_a[27:24], i_b[27:24]) + mul4(w_sgn, i_a[31:28], i_b[31:28]);
   end

   // S1 register, held while the pipeline is stalled.
   always_ff @(posedge i_clk) begin
      if (i_enable) begin
         r_p8  <= w_p8;
         r_p4  <= w_p4;
         r_fmt <= i_fmt;
      end
   end

   // S2 lane sum with format select; an invalid format contributes zero.
   always_comb begin
      w_lane = '0;
      w_val  = '0;
      case (r_fmt)
         AG_FMT_I8: begin
            w_lane = PRODW'($signed(r_p8[0])) + PRODW'($signed(r_p8[1]));
            w_val  = PSELW'($signed(w_lane));
         end
         AG_FMT_U8: begin
            w_lane = PRODW'(r_p8[0]) + PRODW'(r_p8[1]);
            w_val  = PSELW'(w_lane);
         end
         AG_FMT_I4: begin
            w_lane = PRODW'($signed(r_p4[0])) + PRODW'($signed(r_p4[1]));
            w_val  = PSELW'($signed(w_lane));
         end
         AG_FMT_U4: begin
            w_lane = PRODW'(r_p4[0]) + PRODW'(r_p4[1]);
            w_val  = PSELW'(w_lane);
         end
         default: begin
            w_lane = '0;
            w_val  = '0;
         end
      endcase
   end

   // S2 register.
   always_ff @(posedge i_clk) begin
      if (i_enable) r_val <= w_val;
   end

   assign o_val = r_val;

endmodule

// File: rtl/vx_ag_tcu_fedp_bscale.sv
// Block-scaled integer fused dot product. Lanes are summed per block, each
// block sum is shifted by its own scale, the blocks are reduced and the
// accumulator is added with optional int32 saturation and an overflow flag.
// Handshake: a beat is taken when enable=1 (valid_in marks it real) and leaves
// LATENCY enabled cycles later with valid_out=1; enable=0 holds every stage.
module vx_ag_tcu_fedp_bscale
   import vx_ag_tcu_fedp_bscale_pkg::*;
#(
   parameter int N         = 8,
   parameter int NB        = 2,
   parameter int SCALEW    = 4,
   parameter int SCALE_MAX = 15,
   parameter int LATENCY   = 7,
   parameter int XLEN      = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   valid_in,
   input  logic [2:0]             fmt_s,
   input  logic                   sat_en,
   input  logic [NB*SCALEW-1:0]   scale_in,
   input  logic [N*XLEN-1:0]      a_row,
   input  logic [N*XLEN-1:0]      b_col,
   input  logic [XLEN-1:0]        c_val,
   output logic                   valid_out,
   output logic [XLEN-1:0]        d_val,
   output logic                   ovf_out,
   output logic                   fmt_err
);

   localparam int BS   = N / NB;
   localparam int LBS  = $clog2(BS);
   localparam int LNB  = $clog2(NB);
   localparam int REDW = PSELW + LBS;
   localparam int SHW  = REDW + SCALE_MAX;
   localparam int FW   = SHW + LNB;
   // Never narrower than a sign-extended int32 so c is never truncated.
   localparam int ACCW = (FW + 1 > 33) ? FW + 1 : 33;
   localparam int SBD  = LATENCY - 1;
   localparam int SHS  = 2 + LBS;
   localparam logic [SCALEW-1:0]     SMAX = SCALEW'(SCALE_MAX);
   localparam logic signed [ACCW-1:0] IMAX = ACCW'(2147483647);
   localparam logic signed [ACCW-1:0] IMIN = ~IMAX;

   if (LATENCY != fedp_bscale_latency(N)) begin : g_lat_chk
      $error("LATENCY must equal 4+clog2(N)");
   end
   if ((N < 2) || ((N & (N - 1)) != 0) || (NB < 1) || (NB > N) || ((NB & (NB - 1)) != 0))
   begin : g_shape_chk
      $error("N and NB must be powers of two with 1<=NB<=N and N>=2");
   end

   // Per-beat side information travelling alongside the datapath.
   typedef struct packed {
      logic                 vld;
      logic                 ferr;
      logic                 sat;
      logic [NB*SCALEW-1:0] scale;
      logic [31:0]          c;
   } sb_t;

   sb_t                     w_sb_in;
   sb_t                     r_sb [1:SBD];
   logic signed [PSELW-1:0] w_lane_val [N];
   logic signed [REDW-1:0]  w_blk [NB];
   logic [SCALEW-1:0]       w_shamt [NB];
   logic signed [SHW-1:0]   r_sh [NB];
   logic signed [FW-1:0]    w_dot;
   logic signed [ACCW-1:0]  w_sum;
   logic                    w_hi;
   logic                    w_lo;
   logic [31:0]             w_d;
   logic                    r_vout;
   logic                    r_ovf;
   logic                    r_ferr;
   logic [31:0]             r_d;

   // Capture the side information of the incoming beat.
   always_comb begin
      w_sb_in       = '0;
      w_sb_in.vld   = valid_in;
      w_sb_in.ferr  = valid_in & ~fmt_is_valid(fmt_s);
      w_sb_in.sat   = sat_en;
      w_sb_in.scale = scale_in;
      w_sb_in.c     = c_val[31:0];
   end

   // Side-information delay line; reset drops every in-flight beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 1; s <= SBD; s++) r_sb[s] <= '0;
      end else if (enable) begin
         r_sb[1] <= w_sb_in;
         for (int s = 2; s <= SBD; s++) r_sb[s] <= r_sb[s-1];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      vx_ag_tcu_fedp_bscale_lane_mul u_lane (
         .i_clk    (clk),
         .i_enable (enable),
         .i_fmt    (fmt_s),
         .i_a      (a_row[i*XLEN +: 32]),
         .i_b      (b_col[i*XLEN +: 32]),
         .o_val    (w_lane_val[i])
      );
   end

   // Intra-block reduction: adjacent lanes pair up, so node k of the last
   // level is exactly block k. Level 0 is the lane S2 register.
   for (genvar l = 0; l <= LBS; l++) begin : g_intra
      logic signed [REDW-1:0] r_lvl [N >> l];
      if (l == 0) begin : g_leaf
         for (genvar j = 0; j < N; j++) begin : g_j
            assign r_lvl[j] = REDW'(w_lane_val[j]);
         end
      end else begin : g_node
         // One registered adder level of the block tree.
         always_ff @(posedge clk) begin
            if (enable) begin
               for (int j = 0; j < (N >> l); j++)
                  r_lvl[j] <= g_intra[l-1].r_lvl[2*j] + g_intra[l-1].r_lvl[2*j+1];
            end
         end
      end
   end

   for (genvar k = 0; k < NB; k++) begin : g_blk
      assign w_blk[k] = g_intra[LBS].r_lvl[k];
   end

   // Clamp each block scale to the largest supported shift.
   always_comb begin
      for (int k = 0; k < NB; k++) begin
         w_shamt[k] = (r_sb[SHS].scale[k*SCALEW +: SCALEW] > SMAX) ?
                      SMAX : r_sb[SHS].scale[k*SCALEW +: SCALEW];
      end
   end

   // Shift stage: widen each block sum and apply its scale.
   always_ff @(posedge clk) begin
      if (enable) begin
         for (int k = 0; k < NB; k++) r_sh[k] <= SHW'(w_blk[k]) <<< w_shamt[k];
      end
   end

   // Inter-block reduction of the scaled block sums.
   for (genvar l = 0; l <= LNB; l++) begin : g_inter
      logic signed [FW-1:0] r_lvl [NB >> l];
      if (l == 0) begin : g_leaf
         for (genvar j = 0; j < NB; j++) begin : g_j
            assign r_lvl[j] = FW'(r_sh[j]);
         end
      end else begin : g_node
         // One registered adder level of the block-combining tree.
         always_ff @(posedge clk) begin
            if (enable) begin
               for (int j = 0; j < (NB >> l); j++)
                  r_lvl[j] <= g_inter[l-1].r_lvl[2*j] + g_inter[l-1].r_lvl[2*j+1];
            end
         end
      end
   end

   assign w_dot = g_inter[LNB].r_lvl[0];

   // Full-width accumulate, range check and optional saturation.
   always_comb begin
      w_sum = ACCW'(w_dot) + ACCW'($signed(r_sb[SBD].c));
      w_hi  = (w_sum > IMAX);
      w_lo  = (w_sum < IMIN);
      w_d   = w_sum[31:0];
      if (r_sb[SBD].sat && w_hi) w_d = 32'h7FFF_FFFF;
      if (r_sb[SBD].sat && w_lo) w_d = 32'h8000_0000;
   end

   // Output register; overflow is per beat, never sticky.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vout <= 1'b0;
         r_ovf  <= 1'b0;
         r_ferr <= 1'b0;
         r_d    <= '0;
      end else if (enable) begin
         r_vout <= r_sb[SBD].vld;
         r_ovf  <= w_hi | w_lo;
         r_ferr <= r_sb[SBD].ferr;
         r_d    <= w_d;
      end
   end

   assign valid_out = r_vout;
   assign ovf_out   = r_ovf;
   assign fmt_err   = r_ferr;

   if (XLEN > 32) begin : g_dwide
      assign d_val = {{(XLEN-32){1'b1}}, r_d};
   end else begin : g_dnarrow
      assign d_val = r_d;
   end

endmodule

// File: tb/tb_vx_ag_tcu_fedp_bscale.sv
// Directed bench for the block-scaled dot product (N=8, NB=2, XLEN=32).
module tb_vx_ag_tcu_fedp_bscale;
   import vx_ag_tcu_fedp_bscale_pkg::*;

   localparam int N    = 8;
   localparam int NB   = 2;
   localparam int SW   = 4;
   localparam int XLEN = 32;
   localparam int LAT  = 7;

   logic                clk = 1'b0;
   logic                reset;
   logic                enable;
   logic                valid_in;
   logic [2:0]          fmt_s;
   logic                sat_en;
   logic [NB*SW-1:0]    scale_in;
   logic [N*XLEN-1:0]   a_row;
   logic [N*XLEN-1:0]   b_col;
   logic [XLEN-1:0]     c_val;
   logic                valid_out;
   logic [XLEN-1:0]     d_val;
   logic                ovf_out;
   logic                fmt_err;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          bi;
   logic        v;
   logic [31:0] ed;
   logic        pv [LAT];
   logic [31:0] pd [LAT];

   vx_ag_tcu_fedp_bscale #(
      .N(N), .NB(NB), .SCALEW(SW), .SCALE_MAX(15), .LATENCY(LAT), .XLEN(XLEN)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .valid_in  (valid_in),
      .fmt_s     (fmt_s),
      .sat_en    (sat_en),
      .scale_in  (scale_in),
      .a_row     (a_row),
      .b_col     (b_col),
      .c_val     (c_val),
      .valid_out (valid_out),
      .d_val     (d_val),
      .ovf_out   (ovf_out),
      .fmt_err   (fmt_err)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic vi, input logic [2:0] f, input logic [31:0] aw,
                           input logic [31:0] bw, input logic [7:0] sc,
                           input logic [31:0] c, input logic sat);
      valid_in = vi;
      fmt_s    = f;
      a_row    = {N{aw}};
      b_col    = {N{bw}};
      scale_in = sc;
      c_val    = c;
      sat_en   = sat;
   endtask

   // Issue one beat, confirm it is absent one cycle early and present at LAT.
   task automatic single(input string tag, input logic [2:0] f, input logic [31:0] aw,
                         input logic [31:0] bw, input logic [7:0] sc, input logic [31:0] c,
                         input logic sat, input logic [31:0] exp_d, input logic exp_ovf,
                         input logic exp_ferr);
      set_beat(1'b1, f, aw, bw, sc, c, sat);
      tick();
      valid_in = 1'b0;
      repeat (LAT - 2) tick();
      check({tag, " early_valid"}, 32'(valid_out), 32'd0);
      tick();
      check({tag, " valid"}, 32'(valid_out), 32'd1);
      check({tag, " d_val"}, d_val, exp_d);
      check({tag, " ovf"}, 32'(ovf_out), 32'(exp_ovf));
      check({tag, " fmt_err"}, 32'(fmt_err), 32'(exp_ferr));
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b1;
      set_beat(1'b0, 3'd0, 32'd0, 32'd0, 8'd0, 32'd0, 1'b0);
      tick();
      tick();
      check("reset valid_out", 32'(valid_out), 32'd0);
      check("reset d_val", d_val, 32'd0);
      check("reset ovf_out", 32'(ovf_out), 32'd0);
      check("reset fmt_err", 32'(fmt_err), 32'd0);
      reset = 1'b0;
      tick();

      // Basic i8, block scaling, saturation/wrap both directions.
      single("i8 ones", AG_FMT_I8, 32'h01010101, 32'h01010101, 8'h00, 32'd0, 1'b0, 32'd32, 1'b0, 1'b0);
      single("i8 scale3", AG_FMT_I8, 32'h01010101, 32'h01010101, 8'h03, 32'd0, 1'b0, 32'd144, 1'b0, 1'b0);
      single("i8 ovf sat", AG_FMT_I8, 32'h80808080, 32'h80808080, 8'hCC, 32'd0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0);
      single("i8 ovf wrap", AG_FMT_I8, 32'h80808080, 32'h80808080, 8'hCC, 32'd0, 1'b0, 32'h80000000, 1'b1, 1'b0);
      single("i8 neg ovf sat", AG_FMT_I8, 32'h80808080, 32'h7F7F7F7F, 8'hCC, -32'sd20000000, 1'b1, 32'h80000000, 1'b1, 1'b0);
      single("i8 neg ovf wrap", AG_FMT_I8, 32'h80808080, 32'h7F7F7F7F, 8'hCC, -32'sd20000000, 1'b0, 32'h7FCED300, 1'b1, 1'b0);
      single("i8 negative", AG_FMT_I8, 32'h01010101, 32'hFFFFFFFF, 8'h00, -32'sd5, 1'b1, 32'hFFFFFFDB, 1'b0, 1'b0);
      single("u8 max", AG_FMT_U8, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00, 32'd0, 1'b0, 32'h001FC020, 1'b0, 1'b0);
      single("u4 max", AG_FMT_U4, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00, 32'd100, 1'b0, 32'd14500, 1'b0, 1'b0);
      single("i4 minus1", AG_FMT_I4, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00, 32'd100, 1'b0, 32'd164, 1'b0, 1'b0);
      single("bad fmt", 3'd6, 32'h01010101, 32'h01010101, 8'h33, 32'd100, 1'b1, 32'd100, 1'b0, 1'b1);

      // Stream of 10 beats with bubbles and a 3-cycle stall.
      for (int k = 0; k < LAT; k++) begin
         pv[k] = 1'b0;
         pd[k] = '0;
      end
      bi = 0;
      for (int cyc = 0; cyc < 13; cyc++) begin
         if (cyc >= 8 && cyc < 11) begin
            enable = 1'b0;
            set_beat(1'b1, AG_FMT_U8, $urandom, $urandom, 8'($urandom), $urandom, 1'b1);
            tick();
         end else begin
            enable = 1'b1;
            v  = ((bi % 3) != 2);
            ed = 32'(16 * (bi + 1) * (1 << (bi % 4)) + 16 * (bi + 1) + 1000 * bi);
            set_beat(v, AG_FMT_I8, 32'h01010101, {4{8'(bi + 1)}}, {4'd0, 4'(bi % 4)},
                     32'(1000 * bi), 1'b0);
            tick();
            for (int k = LAT - 1; k > 0; k--) begin
               pv[k] = pv[k-1];
               pd[k] = pd[k-1];
            end
            pv[0] = v;
            pd[0] = ed;
            bi++;
         end
         check("stream valid", 32'(valid_out), 32'(pv[LAT-1]));
         if (pv[LAT-1]) check("stream d_val", d_val, pd[LAT-1]);
      end
      enable   = 1'b1;
      valid_in = 1'b0;
      for (int cyc = 0; cyc < LAT + 1; cyc++) begin
         tick();
         for (int k = LAT - 1; k > 0; k--) begin
            pv[k] = pv[k-1];
            pd[k] = pd[k-1];
         end
         pv[0] = 1'b0;
         check("drain valid", 32'(valid_out), 32'(pv[LAT-1]));
         if (pv[LAT-1]) check("drain d_val", d_val, pd[LAT-1]);
      end

      // Reset with four beats in flight.
      for (int k = 0; k < 4; k++) begin
         set_beat(1'b1, AG_FMT_I4, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h11, 32'd7, 1'b0);
         tick();
      end
      valid_in = 1'b0;
      reset    = 1'b1;
      tick();
      check("midreset valid_out", 32'(valid_out), 32'd0);
      check("midreset d_val", d_val, 32'd0);
      check("midreset ovf_out", 32'(ovf_out), 32'd0);
      reset = 1'b0;
      for (int k = 0; k < LAT; k++) begin
         tick();
         check("post-reset no valid", 32'(valid_out), 32'd0);
      end
      single("after reset", AG_FMT_I8, 32'h01010101, 32'h01010101, 8'h00, 32'd0, 1'b0, 32'd32, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/vx_ag_tcu_fedp_bscale.md
Name: VX_ag_tcu_fedp_bscale

Overview:
Block-scaled integer fused dot-product unit for the AG tensor core. It is the next generation of the single-scale FEDP.
- Lanes are grouped into NB blocks. Each block carries its own left-shift scale, applied before the cross-block reduction (microscaling-style).
- Adds valid tracking, optional int32 saturation and an overflow flag.
- Sits in the AG-TCU execute datapath, one instance per output element.

Parameters:
N, 8, lanes (XLEN words) per dot product; power of two, >=2
NB, 2, scale blocks; power of two, 1<=NB<=N; block size BS=N/NB
SCALEW, 4, width of each block scale field
SCALE_MAX, 15, largest applied shift; larger inputs clamp to SCALE_MAX
LATENCY, 7, must equal 4+$clog2(N); static assert

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
enable  in  1  pipeline advance; low = all stages hold
valid_in  in  1  input beat valid (sampled only when enable=1)
fmt_s  in  3  1=i8, 2=u8, 3=i4, 4=u4, others invalid
sat_en  in  1  1 = saturate result to int32, 0 = wrap
scale_in  in  NB*SCALEW  per-block unsigned shift; block k uses bits [k*SCALEW +: SCALEW]
a_row  in  N*XLEN  A operands, packed 4xi8/u8 or 8xi4/u4 in low 32 bits of each lane
b_col  in  N*XLEN  B operands, same packing as a_row
c_val  in  XLEN  accumulator input (int32 in low 32 bits)
valid_out  out  1  d_val valid
d_val  out  XLEN  result; with XLEN=64 upper word is 32'hFFFFFFFF
ovf_out  out  1  true result lay outside int32 range
fmt_err  out  1  beat carried an invalid fmt_s

Behaviour:
Clock and reset:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset clears the valid pipeline, valid_out, ovf_out and fmt_err to 0, and d_val to 0 (upper word FFFFFFFF when XLEN=64).
- Data registers need not be reset.
- Reset mid-operation discards all in-flight beats; no valid_out for them.

Enable and valid:
- enable=0 freezes every stage, including the valid, fmt, scale, sat_en and c delay lines. Outputs hold their values.
- A beat enters only when enable=1. It emerges exactly LATENCY enabled cycles later.
- valid_out=1 only for beats sampled with valid_in=1. Bubbles propagate as valid=0. Data regs may update on bubbles.

Pipeline stages, in order:
- S1, partial products: same packing and signedness as the current FEDP. Each 32-bit lane yields two 17-bit pair sums for 8-bit formats, or two 10-bit quad sums for 4-bit formats.
- S2, lane sum and format select: 18-bit lane sum, sign- or zero-extended to PSELW=19. Invalid fmt forces the lane value to 0 and sets the beat's fmt_err.
- Intra-block tree: log2(BS) registered adder levels at width REDW=19+log2(BS), signed.
- Shift stage: 1 cycle.
  - Block sum is arithmetically shifted left by min(scale,SCALE_MAX) into SHW=REDW+SCALE_MAX bits.
  - Scale is delayed to align with block data.
- Inter-block tree: log2(NB) registered levels at FW=SHW+log2(NB).
- Accumulate: 1 cycle.
  - sum = sext(dot,FW+1) + sext(c,FW+1), computed at full width with no truncation before the range check.
  - ovf = sum > 2^31-1 or sum < -2^31.
  - d_val = sat_en ? clamp(sum) : sum[31:0].
  - ovf_out is registered with d_val and is not sticky.

Invalid format:
- fmt_err=1 returns d_val = c (dot=0) and ovf_out=0.

Decomposition:
- Shared package VX_ag_tcu_pkg:
  - fmt_s encodings (AG_FMT_I8/U8/I4/U4).
  - PRODW=18 and PSELW=19.
  - A latency function fedp_bscale_latency(N) = 4+$clog2(N).
- Sub-module VX_ag_tcu_lane_mul: one lane's S1/S2 (packed products plus format select), instantiated N times.
- Trees and delay lines use VX_pipe_register.

Test Plan:
1. N=8, NB=2, i8, all a/b lanes 32'h01010101, scales 0/0, c=0 -> d_val=32 after 7 cycles; ovf_out=0, fmt_err=0.
2. Same operands, scale block0=3, block1=0, c=0 -> 16<<3 + 16 = 144.
3. i8, all bytes 8'h80, all scales 12, c=0 -> sum 2^31. sat_en=1 -> 32'h7FFFFFFF with ovf_out=1; sat_en=0 -> 32'h80000000 with ovf_out=1.
4. u4, all words 32'hFFFFFFFF, c=100 -> 14500. Repeat as i4 with scales 0 -> 64+100=164. fmt_s=6 -> d_val=100, fmt_err=1.
5. Back-to-back 10 beats with valid_in toggling and enable low for 3 cycles mid-stream -> results in order, gaps match bubbles, each latency = 7 + stall cycles, outputs frozen while enable=0.
6. Reset asserted with 4 beats in flight -> valid_out=0, d_val=0 next cycle. No stale valid_out in the following 7 cycles; a new beat then completes normally.
